// File: rtl/char_buf_if.sv
// char_buf_if: renderer read port, two arbitrated write ports, clear control
// and vertical-blank input for char_buf_ctrl.
//   master: the side that issues reads, writes and clears (renderer/writers)
//   slave : the buffer controller
interface char_buf_if #(
    parameter int AW = 8
);
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          req0;
    logic [AW-1:0] addr0;
    logic [7:0]    data0;
    logic          ack0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [7:0]    data1;
    logic          ack1;
    logic          clr_req;
    logic          busy;
    logic          vblnk;

    modport master (
        output rd_addr, req0, addr0, data0, req1, addr1, data1, clr_req, vblnk,
        input  rd_data, ack0, ack1, busy
    );

    modport slave (
        input  rd_addr, req0, addr0, data0, req1, addr1, data1, clr_req, vblnk,
        output rd_data, ack0, ack1, busy
    );
endinterface

// File: rtl/char_buf_ctrl.sv
// char_buf_ctrl: character-code buffer for the text renderer.
//  - 1-cycle registered read port, read-before-write on address collision.
//  - One write port shared by two requesters through a round-robin arbiter.
//  - Clear sequencer fills every entry with BLANK_CHAR after reset and on
//    clr_req; the clear owns the write port and holds off all acks.
// Build option: define VBLANK_WR_EN to restrict all writes (arbitrated and
// clear) to cycles with vblnk=1; otherwise vblnk is ignored.
module char_buf_ctrl #(
    parameter int         DEPTH      = 256,
    parameter int         AW         = 8,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic   clk,
    input  logic   rst,
    char_buf_if.slave bus
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_CLEAR = 1'b1;
    localparam logic [AW:0] CLR_LAST = (AW+1)'(DEPTH - 1);

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_req_t;

    logic [0:0]    state;
    logic [AW:0]   clr_cnt;
    logic          last_grant;
    logic [7:0]    mem [DEPTH];

    wr_req_t [1:0] port_req;
    logic [1:0]    gnt;
    logic          wr_win;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

`ifdef VBLANK_WR_EN
    // Writes only land during vertical blanking to avoid mid-frame tearing.
    assign wr_win = bus.vblnk;
`else
    logic unused_vblnk;
    assign unused_vblnk = bus.vblnk;
    assign wr_win       = 1'b1;
`endif

    assign port_req[0] = '{vld: bus.req0, addr: bus.addr0, data: bus.data0};
    assign port_req[1] = '{vld: bus.req1, addr: bus.addr1, data: bus.data1};

    // Round-robin grant: idle only, a clear request wins over both ports,
    // contention goes to the port that was not granted last.
    always_comb begin
        gnt = 2'b00;
        if (!rst && state == ST_IDLE && !bus.clr_req && wr_win) begin
            case ({port_req[1].vld, port_req[0].vld})
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Single write port mux: clear sequencer or the granted requester.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                if (wr_win) begin
                    wr_en   = 1'b1;
                    wr_addr = clr_cnt[AW-1:0];
                    wr_data = BLANK_CHAR;
                end
            end else if (gnt[0]) begin
                wr_en   = 1'b1;
                wr_addr = port_req[0].addr;
                wr_data = port_req[0].data;
            end else if (gnt[1]) begin
                wr_en   = 1'b1;
                wr_addr = port_req[1].addr;
                wr_data = port_req[1].data;
            end
        end
    end

    // Acks are the grant itself, so they coincide with the committing edge.
    assign bus.ack0 = gnt[0];
    assign bus.ack1 = gnt[1];
    assign bus.busy = rst || (state == ST_CLEAR);

    // Buffer storage; contents are initialised by the clear, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Registered read; a same-cycle write to rd_addr shows up one read later.
    always_ff @(posedge clk) begin
        if (rst)
            bus.rd_data <= 8'h00;
        else
            bus.rd_data <= mem[bus.rd_addr];
    end

    // Control FSM: clear sweep, idle arbitration bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end else if (gnt != 2'b00) begin
                        last_grant <= gnt[1];
                    end
                end
                default: begin
                    // Counter holds while the write window is closed.
                    if (wr_win) begin
                        if (clr_cnt == CLR_LAST) begin
                            state   <= ST_IDLE;
                            clr_cnt <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_buf_ctrl.sv
// tb_char_buf_ctrl: directed scenarios plus randomized traffic for
// char_buf_ctrl. A per-cycle reference model (array memory, clear countdown,
// last-granted port) predicts acks, busy and read data; a monitor on the
// falling edge compares the DUT against the queued predictions.
module tb_char_buf_ctrl;

    localparam int         DEPTH = 256;
    localparam int         AW    = 8;
    localparam logic [7:0] BLANK = 8'h20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    char_buf_if #(.AW(AW)) bus ();

    char_buf_ctrl #(.DEPTH(DEPTH), .AW(AW), .BLANK_CHAR(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int   tag;
        logic a0;
        logic a1;
        logic bsy;
    } out_t;

    typedef struct {
        int         tag;
        logic [7:0] d;
    } rd_t;

    out_t       out_q[$];
    rd_t        rd_q[$];
    int         cyc      = 0;
    int         n_chk    = 0;
    int         n_err    = 0;
    logic [7:0] ref_mem [DEPTH];
    int         clr_left = 0;
    int         m_last   = 1;
    int         last_g   = -1;

    // Predict this cycle's outputs from the inputs currently driven, advance
    // the model, then move to the next cycle (inputs change #1 after posedge).
    task automatic tick();
        out_t o;
        rd_t  r;
        bit   wr_ok;
        int   g;
        g     = -1;
        wr_ok = 1'b1;
`ifdef VBLANK_WR_EN
        wr_ok = bus.vblnk;
`endif
        r.tag = cyc;
        r.d   = rst ? 8'h00 : ref_mem[bus.rd_addr];
        o.tag = cyc;
        o.bsy = 1'b1;
        if (rst) begin
            clr_left = DEPTH;
            m_last   = 1;
        end else if (clr_left > 0) begin
            if (wr_ok) begin
                ref_mem[DEPTH - clr_left] = BLANK;
                clr_left--;
            end
        end else begin
            o.bsy = 1'b0;
            if (bus.clr_req) begin
                clr_left = DEPTH;
            end else if (wr_ok) begin
                if (bus.req0 && bus.req1) g = 1 - m_last;
                else if (bus.req0)        g = 0;
                else if (bus.req1)        g = 1;
                if (g == 0) ref_mem[bus.addr0] = bus.data0;
                if (g == 1) ref_mem[bus.addr1] = bus.data1;
                if (g >= 0) m_last = g;
            end
        end
        o.a0   = (g == 0);
        o.a1   = (g == 1);
        last_g = g;
        out_q.push_back(o);
        rd_q.push_back(r);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Requester behaviour after a cycle: drop on reset, after an ack either
    // stream another write or release, otherwise occasionally raise a request.
    task automatic upd_reqs(input bit was_rst);
        if (was_rst) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end else begin
            if (bus.req0 && last_g == 0) begin
                bus.req0  = $urandom_range(0, 1) == 1;
                bus.addr0 = 8'($urandom);
                bus.data0 = 8'($urandom);
            end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                bus.req0  = 1'b1;
                bus.addr0 = 8'($urandom);
                bus.data0 = 8'($urandom);
            end
            if (bus.req1 && last_g == 1) begin
                bus.req1  = $urandom_range(0, 1) == 1;
                bus.addr1 = 8'($urandom);
                bus.data1 = 8'($urandom);
            end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                bus.req1  = 1'b1;
                bus.addr1 = 8'($urandom);
                bus.data1 = 8'($urandom);
            end
        end
    endtask

    // Monitor: control outputs checked in their own cycle, read data one
    // cycle after the address was presented.
    always @(negedge clk) begin
        out_t e;
        rd_t  r;
        if (out_q.size() > 0 && out_q[0].tag == cyc) begin
            e = out_q.pop_front();
            n_chk++;
            if ({bus.ack0, bus.ack1, bus.busy} !== {e.a0, e.a1, e.bsy}) begin
                n_err++;
                $display("FAIL ctl cyc=%0d ack0/ack1/busy got=%b%b%b exp=%b%b%b",
                         cyc, bus.ack0, bus.ack1, bus.busy, e.a0, e.a1, e.bsy);
            end
        end
        if (rd_q.size() > 0 && rd_q[0].tag == cyc - 1) begin
            r = rd_q.pop_front();
            if (!$isunknown(r.d)) begin
                n_chk++;
                if (bus.rd_data !== r.d) begin
                    n_err++;
                    $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, bus.rd_data, r.d);
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.rd_addr = '0;
        bus.req0    = 1'b0;
        bus.addr0   = '0;
        bus.data0   = '0;
        bus.req1    = 1'b0;
        bus.addr1   = '0;
        bus.data1   = '0;
        bus.clr_req = 1'b0;
        bus.vblnk   = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;
        @(posedge clk);
        #1;

        // Reset, full post-reset clear, then sweep every address.
        repeat (2) tick();
        rst = 1'b0;
        repeat (DEPTH) tick();
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_addr = 8'(i);
            tick();
        end

        // Single write from port 0 with a colliding read (old data first).
        bus.req0    = 1'b1;
        bus.addr0   = 8'h12;
        bus.data0   = 8'h41;
        bus.rd_addr = 8'h12;
        tick();
        bus.req0 = 1'b0;
        tick();
        tick();

        // Contention after reset: grants alternate starting with port 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (DEPTH) tick();
        bus.req0  = 1'b1;
        bus.addr0 = 8'h30;
        bus.data0 = 8'hA0;
        bus.req1  = 1'b1;
        bus.addr1 = 8'h40;
        bus.data1 = 8'hB0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (last_g == 0) begin bus.addr0 = bus.addr0 + 1'b1; bus.data0 = 8'($urandom); end
            if (last_g == 1) begin bus.addr1 = bus.addr1 + 1'b1; bus.data1 = 8'($urandom); end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 8'h30; i < 8'h34; i++) begin
            bus.rd_addr = 8'(i);
            tick();
        end

        // Pending port-1 write held off by a clear, then survives it.
        bus.req1    = 1'b1;
        bus.addr1   = 8'h55;
        bus.data1   = 8'hA5;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (DEPTH) tick();
        tick();
        bus.req1    = 1'b0;
        bus.rd_addr = 8'h55;
        tick();
        tick();

        // Reset in the middle of a clear restarts the whole sweep.
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (DEPTH) tick();
        tick();

        // Write window closed, then opened; clear with a toggling window.
        bus.vblnk = 1'b0;
        bus.req0  = 1'b1;
        bus.addr0 = 8'h77;
        bus.data0 = 8'h99;
        repeat (3) tick();
        bus.vblnk = 1'b1;
        tick();
        bus.req0    = 1'b0;
        bus.rd_addr = 8'h77;
        tick();
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 600; k++) begin
            bus.vblnk   = $urandom_range(0, 1) == 1;
            bus.rd_addr = 8'($urandom);
            tick();
        end

        // Randomized traffic with occasional clears and resets.
        for (int k = 0; k < 2500; k++) begin
            bit was_rst;
            rst         = $urandom_range(0, 399) == 0;
            bus.clr_req = !rst && ($urandom_range(0, 149) == 0);
            bus.vblnk   = $urandom_range(0, 3) != 0;
            bus.rd_addr = 8'($urandom);
            was_rst     = rst;
            tick();
            upd_reqs(was_rst);
        end

        // Drain, let any clear finish, then read the whole buffer back.
        rst         = 1'b0;
        bus.clr_req = 1'b0;
        bus.req0    = 1'b0;
        bus.req1    = 1'b0;
        bus.vblnk   = 1'b1;
        repeat (DEPTH + 2) tick();
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_addr = 8'(i);
            tick();
        end
        tick();
        @(negedge clk);
        #1;
        n_chk++;
        if (out_q.size() != 0 || rd_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending out=%0d rd=%0d exp=0/0", out_q.size(), rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
